// File: rtl/lcd_register_display.sv
// HD44780-style 4-bit LCD driver: power-up/init/config sequence, then on Start
// shows "R<i>=<dddddddd>" for a captured register index and 32-bit value.
module lcd_register_display #(
  parameter int unsigned POWERUP_CYCLES   = 15,
  parameter int unsigned LONG_WAIT_CYCLES = 5,
  parameter int unsigned CMD_WAIT_CYCLES  = 2,
  parameter int unsigned E_PULSE_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic [3:0]  RegisterIndex,
  input  logic [31:0] RegisterData,
  output logic        Ready,
  output logic        LCDE,
  output logic        LCDRS,
  output logic        LCDRW,
  output logic [3:0]  LCDAT
);

  localparam int unsigned MAX_A = (POWERUP_CYCLES > LONG_WAIT_CYCLES) ? POWERUP_CYCLES : LONG_WAIT_CYCLES;
  localparam int unsigned MAX_B = (CMD_WAIT_CYCLES > E_PULSE_CYCLES) ? CMD_WAIT_CYCLES : E_PULSE_CYCLES;
  localparam int unsigned MAXV  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CW    = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_CONFIG, ST_IDLE, ST_SETADDR, ST_WRITE
  } state_e;

  typedef enum logic [1:0] {PH_SETUP, PH_EHIGH, PH_HOLD, PH_WAIT} phase_e;

  state_e        st_q, st_d;
  phase_e        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          lo_q, lo_d;
  logic [3:0]    nib_q, nib_d;
  logic          rs_q, rs_d;
  logic [3:0]    ridx_q, ridx_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          launch;
  logic [CW-1:0] wait_last;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  function automatic logic [7:0] byte_of(input state_e s, input logic [3:0] i,
                                         input logic [3:0] ri, input logic [31:0] rd);
    logic [2:0] dig;
    dig = 3'(4'd10 - i);
    case (s)
      ST_CONFIG: begin
        case (i)
          4'd0:    return 8'h28;
          4'd1:    return 8'h06;
          4'd2:    return 8'h0C;
          default: return 8'h01;
        endcase
      end
      ST_SETADDR: return 8'h80;
      ST_WRITE: begin
        case (i)
          4'd0:    return 8'h52;
          4'd1:    return hex_char(ri);
          4'd2:    return 8'h3D;
          default: return hex_char(rd[{dig, 2'b00} +: 4]);
        endcase
      end
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      st_q   <= ST_POWERUP;
      ph_q   <= PH_SETUP;
      cnt_q  <= '0;
      idx_q  <= '0;
      lo_q   <= 1'b0;
      nib_q  <= '0;
      rs_q   <= 1'b0;
      ridx_q <= '0;
      rdat_q <= '0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      lo_q   <= lo_d;
      nib_q  <= nib_d;
      rs_q   <= rs_d;
      ridx_q <= ridx_d;
      rdat_q <= rdat_d;
    end
  end

  assign cur_byte  = byte_of(st_q, idx_q, ridx_q, rdat_q);
  assign wait_last = ((st_q == ST_INIT) || (st_q == ST_CONFIG && idx_q == 4'd3))
                     ? CW'(LONG_WAIT_CYCLES - 1) : CW'(CMD_WAIT_CYCLES - 1);

  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    lo_d   = lo_q;
    nib_d  = nib_q;
    rs_d   = rs_q;
    ridx_d = ridx_q;
    rdat_d = rdat_q;
    launch = 1'b0;
    case (st_q)
      // The cycle in which reset is released is not counted, hence the compare
      // against POWERUP_CYCLES rather than POWERUP_CYCLES-1.
      ST_POWERUP: begin
        if (cnt_q == CW'(POWERUP_CYCLES)) begin
          st_d   = ST_INIT;
          idx_d  = '0;
          launch = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (Start) begin
          ridx_d = RegisterIndex;
          rdat_d = RegisterData;
          st_d   = ST_SETADDR;
          idx_d  = '0;
          launch = 1'b1;
        end
      end
      default: begin
        case (ph_q)
          PH_SETUP: begin
            ph_d  = PH_EHIGH;
            cnt_d = '0;
          end
          PH_EHIGH: begin
            if (cnt_q == CW'(E_PULSE_CYCLES - 1)) begin
              ph_d  = PH_HOLD;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PH_HOLD: begin
            if (st_q != ST_INIT && !lo_q) begin
              ph_d  = PH_SETUP;
              lo_d  = 1'b1;
              nib_d = cur_byte[3:0];
            end else begin
              ph_d  = PH_WAIT;
              cnt_d = '0;
            end
          end
          default: begin
            if (cnt_q == wait_last) begin
              case (st_q)
                ST_INIT: begin
                  if (idx_q == 4'd3) begin
                    st_d  = ST_CONFIG;
                    idx_d = '0;
                  end else begin
                    idx_d = idx_q + 4'd1;
                  end
                  launch = 1'b1;
                end
                ST_CONFIG: begin
                  if (idx_q == 4'd3) begin
                    st_d = ST_IDLE;
                  end else begin
                    idx_d  = idx_q + 4'd1;
                    launch = 1'b1;
                  end
                end
                ST_SETADDR: begin
                  st_d   = ST_WRITE;
                  idx_d  = '0;
                  launch = 1'b1;
                end
                default: begin
                  if (idx_q == 4'd10) begin
                    st_d = ST_IDLE;
                  end else begin
                    idx_d  = idx_q + 4'd1;
                    launch = 1'b1;
                  end
                end
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
    endcase
    // New item: load its first nibble so it is valid during the setup cycle.
    if (launch) begin
      ph_d  = PH_SETUP;
      lo_d  = 1'b0;
      cnt_d = '0;
      rs_d  = (st_d == ST_WRITE);
      nib_d = (st_d == ST_INIT) ? ((idx_d == 4'd3) ? 4'h2 : 4'h3)
                                : byte_of(st_d, idx_d, ridx_d, rdat_d) >> 4;
    end
  end

  always_comb begin
    LCDE  = (ph_q == PH_EHIGH) && (st_q != ST_POWERUP) && (st_q != ST_IDLE);
    LCDRS = rs_q;
    LCDAT = nib_q;
    LCDRW = 1'b0;
    Ready = (st_q == ST_IDLE);
  end

endmodule
